// File: rtl/dram_read_scheduler.sv
// Read-request scheduler in front of a single-bank DRAM model: FIFO-buffers client rows,
// issues them one at a time to the bank and returns tagged responses in request order.
module dram_read_scheduler #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ROW_W   = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ROW_W-1:0]  req_row,
  output logic              req_ready,
  output logic [ROW_W-1:0]  bank_row_no,
  output logic              bank_input_valid,
  input  logic              bank_output_valid,
  input  logic [DATA_W-1:0] bank_row_data,
  output logic              resp_valid,
  output logic [ROW_W-1:0]  resp_row,
  output logic [DATA_W-1:0] resp_data,
  output logic [1:0]        resp_latency,
  output logic              resp_err,
  output logic              busy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned LAT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RECOVER
  } state_t;

  state_t state, state_d;

  logic [ROW_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [LAT_W-1:0] lat;
  logic [1:0]       lat_sat;
  logic             push, pop, rsp_ok, rsp_to;

  // A full FIFO refuses a push even when IDLE pops in the same cycle.
  assign req_ready = (count != FULL);
  assign push      = req_valid && req_ready;
  assign busy      = (state != S_IDLE) || (count != '0);
  assign lat_sat   = (lat > LAT_W'(3)) ? 2'd3 : lat[1:0];

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    rsp_ok  = 1'b0;
    rsp_to  = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bank_output_valid) begin
          rsp_ok  = 1'b1;
          state_d = S_RECOVER;
        end else if (lat == LAT_LAST) begin
          rsp_to  = 1'b1;
          state_d = S_RECOVER;
        end
      end
      S_RECOVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_row;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Strobes are recomputed every cycle, so both pulses are exactly one cycle wide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_input_valid <= 1'b0;
      bank_row_no      <= '0;
      lat              <= '0;
      resp_valid       <= 1'b0;
      resp_row         <= '0;
      resp_data        <= '0;
      resp_latency     <= '0;
      resp_err         <= 1'b0;
    end else begin
      bank_input_valid <= pop;
      resp_valid       <= rsp_ok || rsp_to;
      if (pop) begin
        bank_row_no <= mem[rd_ptr];
        lat         <= '0;
      end else if (state == S_WAIT && !rsp_ok && !rsp_to) begin
        lat <= lat + 1'b1;
      end
      if (rsp_ok) begin
        resp_row     <= bank_row_no;
        resp_data    <= bank_row_data;
        resp_latency <= lat_sat;
        resp_err     <= 1'b0;
      end else if (rsp_to) begin
        resp_row     <= bank_row_no;
        resp_data    <= '0;
        resp_latency <= 2'd3;
        resp_err     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dram_read_scheduler.sv
// Scoreboard bench for dram_read_scheduler: directed requests with a scripted bank model,
// expected responses queued at issue time and checked by an independent monitor.
module tb_dram_read_scheduler;

  localparam int DEPTH   = 4;
  localparam int ROW_W   = 4;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic [ROW_W-1:0]  req_row = '0;
  logic              req_ready;
  logic [ROW_W-1:0]  bank_row_no;
  logic              bank_input_valid;
  logic              bank_output_valid;
  logic              bank_ov_model = 1'b0;
  logic              bank_ov_poke = 1'b0;
  logic [DATA_W-1:0] bank_row_data = '0;
  logic              resp_valid;
  logic [ROW_W-1:0]  resp_row;
  logic [DATA_W-1:0] resp_data;
  logic [1:0]        resp_latency;
  logic              resp_err;
  logic              busy;

  assign bank_output_valid = bank_ov_model | bank_ov_poke;

  dram_read_scheduler #(
    .DEPTH(DEPTH), .ROW_W(ROW_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_row(req_row), .req_ready(req_ready),
    .bank_row_no(bank_row_no), .bank_input_valid(bank_input_valid),
    .bank_output_valid(bank_output_valid), .bank_row_data(bank_row_data),
    .resp_valid(resp_valid), .resp_row(resp_row), .resp_data(resp_data),
    .resp_latency(resp_latency), .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              delay;   // -1: bank never answers
    logic [DATA_W-1:0] data;
    logic [ROW_W-1:0]  row;
  } plan_t;

  typedef struct {
    logic [ROW_W-1:0]  row;
    logic [DATA_W-1:0] data;
    logic [1:0]        lat;
    logic              err;
    int                gap;     // cycles from issue strobe to response
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int last_issue = 0;
  int resp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bank model: answers `delay` negedges after seeing the strobe.
  int bcnt = -1;
  int low_run = 100;
  logic [DATA_W-1:0] bdata = '0;
  always @(negedge clk) begin
    plan_t p;
    bank_ov_model = 1'b0;
    if (rst) begin
      bcnt = -1;
      low_run = 100;
    end else if (bank_input_valid) begin
      chk("strobe_gap", 32'(low_run >= 2), 1);
      low_run = 0;
      last_issue = cyc;
      bcnt = -1;
      if (plan_q.size() == 0) begin
        chk("unexpected_issue", 1, 0);
      end else begin
        p = plan_q.pop_front();
        chk("bank_row_no", 32'(bank_row_no), 32'(p.row));
        bdata = p.data;
        bcnt  = p.delay;
        if (bcnt == 0) begin
          bank_ov_model = 1'b1;
          bank_row_data = bdata;
          bcnt = -1;
        end
      end
    end else begin
      low_run++;
      if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) begin
          bank_ov_model = 1'b1;
          bank_row_data = bdata;
          bcnt = -1;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && resp_valid) begin
      resp_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_row", 32'(resp_row), 32'(e.row));
        chk("resp_data", 32'(resp_data), 32'(e.data));
        chk("resp_latency", 32'(resp_latency), 32'(e.lat));
        chk("resp_err", 32'(resp_err), 32'(e.err));
        chk("resp_gap", 32'(cyc - last_issue), 32'(e.gap));
      end
    end
  end

  task automatic add_req(input logic [ROW_W-1:0] row, input int delay,
                         input logic [DATA_W-1:0] data, input bit expect_resp);
    plan_t p;
    exp_t  e;
    int n;
    p.delay = delay; p.data = data; p.row = row;
    plan_q.push_back(p);
    if (expect_resp) begin
      e.row = row;
      if (delay < 0) begin
        e.data = '0; e.lat = 2'd3; e.err = 1'b1; e.gap = TIMEOUT;
      end else begin
        e.data = data; e.lat = (delay > 3) ? 2'd3 : 2'(delay); e.err = 1'b0; e.gap = delay + 1;
      end
      exp_q.push_back(e);
    end
    req_valid = 1'b1;
    req_row   = row;
    n = 0;
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      chk("push_timeout", 0, 1);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_q.size() != 0) && n < 500);
    if (n >= 500) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual running required finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0;
    int n;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_bank_input_valid", 32'(bank_input_valid), 0);
    chk("rst_bank_row_no", 32'(bank_row_no), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    rst = 1'b0;
    @(negedge clk);

    // miss
    add_req(4'd1, 1, 16'hA5A5, 1'b1);
    wait_idle();

    // conflict then hit on the same row
    add_req(4'd2, 2, 16'h1234, 1'b1);
    add_req(4'd2, 0, 16'h5678, 1'b1);
    wait_idle();

    // full FIFO behind a silent bank
    add_req(4'd11, -1, 16'h0000, 1'b1);
    add_req(4'd7,  0, 16'h0707, 1'b1);
    add_req(4'd14, 1, 16'h1414, 1'b1);
    add_req(4'd14, 2, 16'h4141, 1'b1);
    add_req(4'd15, 3, 16'h1515, 1'b1);
    chk("full_req_ready", 32'(req_ready), 0);
    chk("full_busy", 32'(busy), 1);
    r0 = resp_cnt;
    add_req(4'd3, 5, 16'h0303, 1'b1);
    chk("row3_after_first_resp", 32'(resp_cnt > r0), 1);
    wait_idle();

    // timeout
    r0 = resp_cnt;
    add_req(4'd9, -1, 16'h0000, 1'b1);
    n = 0;
    while (resp_cnt == r0 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 100) chk("timeout_resp_missing", 0, 1);
    @(negedge clk); #1;
    chk("timeout_busy_drop", 32'(busy), 0);
    wait_idle();

    // simultaneous push and pop with two entries queued
    add_req(4'd4, 0, 16'h4444, 1'b1);
    add_req(4'd5, 0, 16'h5555, 1'b1);
    add_req(4'd6, 0, 16'h6666, 1'b1);
    @(negedge clk);
    add_req(4'd8, 0, 16'h8888, 1'b1);
    chk("pushpop_count", 32'(dut.count), 2);
    chk("pushpop_issue", 32'(bank_input_valid), 1);
    wait_idle();

    // reset while waiting on the bank
    add_req(4'd5, -1, 16'h0000, 1'b0);
    add_req(4'd6, -1, 16'h0000, 1'b0);
    add_req(4'd7, -1, 16'h0000, 1'b0);
    n = 0;
    while (!(busy && !bank_input_valid && dut.state == dut.S_WAIT) && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_bank_input_valid", 32'(bank_input_valid), 0);
    chk("mid_rst_bank_row_no", 32'(bank_row_no), 0);
    chk("mid_rst_resp_valid", 32'(resp_valid), 0);
    chk("mid_rst_resp_row", 32'(resp_row), 0);
    chk("mid_rst_resp_data", 32'(resp_data), 0);
    chk("mid_rst_resp_latency", 32'(resp_latency), 0);
    chk("mid_rst_resp_err", 32'(resp_err), 0);
    chk("mid_rst_req_ready", 32'(req_ready), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    plan_q.delete();
    r0 = resp_cnt;
    @(negedge clk);
    rst = 1'b0;
    bank_ov_poke = 1'b1;
    @(negedge clk);
    bank_ov_poke = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_no_resp", 32'(resp_cnt - r0), 0);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_req_ready", 32'(req_ready), 1);

    chk("pending_resp", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
